// File: rtl/mips_rf_pkg.sv
// Shared register-file types for the writeback path: address/data widths,
// the hard-wired zero register and the queued writeback entry.
package mips_rf_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/rf_write_queue_if.sv
// Producer-to-queue writeback request channel.
interface rf_write_queue_if;
  import mips_rf_pkg::*;

  // A request transfers on a rising edge where in_valid && in_ready are both 1.
  // in_reg/in_data must be stable while in_valid is high; in_ready does not
  // depend on in_valid.
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] in_reg;
  logic [DATA_W-1:0]     in_data;

  modport master (output in_valid, output in_reg, output in_data, input in_ready);
  modport slave  (input in_valid, input in_reg, input in_data, output in_ready);
endinterface

// File: rtl/rf_fwd_match.sv
// Combinational youngest-match search over the live window of the write queue
// for a single forwarding lookup port.
module rf_fwd_match
  import mips_rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wb_entry_t [DEPTH-1:0]  entries,
  input  logic [AW-1:0]          head,
  input  logic [AW:0]            count,
  input  logic [REG_ADDR_W-1:0]  lookupReg,
  output logic                   hit,
  output logic [DATA_W-1:0]      fwdData
);

  logic [AW-1:0] idx;

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit     = 1'b0;
    fwdData = '0;
    idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (((AW+1)'(i) < count) && (lookupReg != ZERO_REG) &&
          (entries[idx].dest == lookupReg)) begin
        hit     = 1'b1;
        fwdData = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// Register-file write queue: buffers writebacks from multi-cycle producers,
// drains one per cycle into reg_file and forwards queued values to readers.
module rf_write_queue
  import mips_rf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  rf_write_queue_if.slave        push,
  input  logic                   drain_en,
  output logic [REG_ADDR_W-1:0]  writeReg,
  output logic [DATA_W-1:0]      writeData,
  output logic                   regWrite,
  input  logic [REG_ADDR_W-1:0]  lookupReg1,
  input  logic [REG_ADDR_W-1:0]  lookupReg2,
  output logic                   hit1,
  output logic                   hit2,
  output logic [DATA_W-1:0]      fwdData1,
  output logic [DATA_W-1:0]      fwdData2,
  output logic [AW:0]            count
);

  wb_entry_t [DEPTH-1:0] entries;
  logic [AW-1:0]         head;
  logic [AW-1:0]         tail;
  logic                  empty;
  logic                  accept;
  logic                  store;

  assign empty         = (count == '0);
  assign push.in_ready = (count != (AW+1)'(DEPTH));
  assign accept        = push.in_valid && push.in_ready;
  // Writes to $0 complete the handshake but are never stored.
  assign store         = accept && (push.in_reg != ZERO_REG);

  assign regWrite  = !empty && drain_en;
  assign writeReg  = empty ? ZERO_REG : entries[head].dest;
  assign writeData = empty ? '0       : entries[head].data;

  always_ff @(posedge clk) begin
    if (store) begin
      entries[tail] <= '{dest: push.in_reg, data: push.in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (store) begin
        tail <= tail + 1'b1;
      end
      if (regWrite) begin
        head <= head + 1'b1;
      end
      case ({store, regWrite})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  rf_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd1 (
    .entries   (entries),
    .head      (head),
    .count     (count),
    .lookupReg (lookupReg1),
    .hit       (hit1),
    .fwdData   (fwdData1)
  );

  rf_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd2 (
    .entries   (entries),
    .head      (head),
    .count     (count),
    .lookupReg (lookupReg2),
    .hit       (hit2),
    .fwdData   (fwdData2)
  );

endmodule

// File: tb/tb_rf_write_queue.sv
// Bench for rf_write_queue: directed vector table, hand-written reset sequence
// and randomized traffic checked against a queue-based reference model.
module tb_rf_write_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic        v;
    logic [4:0]  r;
    logic [31:0] d;
    logic        de;
    logic [4:0]  l1;
    logic [4:0]  l2;
    logic        e_rdy;
    logic        e_we;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_h1;
    logic [31:0] e_f1;
    logic        e_h2;
    logic [31:0] e_f2;
    logic [2:0]  e_cnt;
  } vec_t;

  // clock / reset / DUT
  logic        clk;
  logic        reset;
  logic        drain_en;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        regWrite;
  logic [4:0]  lookupReg1;
  logic [4:0]  lookupReg2;
  logic        hit1;
  logic        hit2;
  logic [31:0] fwdData1;
  logic [31:0] fwdData2;
  logic [2:0]  count;

  rf_write_queue_if inIf ();

  rf_write_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .push       (inIf),
    .drain_en   (drain_en),
    .writeReg   (writeReg),
    .writeData  (writeData),
    .regWrite   (regWrite),
    .lookupReg1 (lookupReg1),
    .lookupReg2 (lookupReg2),
    .hit1       (hit1),
    .hit2       (hit2),
    .fwdData1   (fwdData1),
    .fwdData2   (fwdData2),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];
  logic [31:0] rf[32];
  logic        e_rdy;
  logic        e_we;
  logic        seen_we;
  logic [4:0]  seen_wr;
  logic [31:0] seen_wd;
  vec_t        vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // driver tasks: inputs change #1 after posedge, outputs sampled at negedge
  task automatic apply(input logic rst_i, input logic v, input logic [4:0] r,
                       input logic [31:0] d, input logic de,
                       input logic [4:0] l1, input logic [4:0] l2);
    reset         = rst_i;
    inIf.in_valid = v;
    inIf.in_reg   = r;
    inIf.in_data  = d;
    drain_en      = de;
    lookupReg1    = l1;
    lookupReg2    = l2;
    @(negedge clk);
    seen_we = regWrite;
    seen_wr = writeReg;
    seen_wd = writeData;
  endtask

  // Reference model: the queue holds {reg, data} in acceptance order.
  task automatic model_check(input string tag);
    int          sz;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_h1, e_h2;
    logic [31:0] e_f1, e_f2;
    sz    = exp_q.size();
    e_rdy = (sz != DEPTH);
    e_we  = (sz != 0) && drain_en;
    e_wr  = (sz != 0) ? exp_q[0][36:32] : 5'd0;
    e_wd  = (sz != 0) ? exp_q[0][31:0] : 32'd0;
    e_h1 = 1'b0; e_f1 = 32'd0; e_h2 = 1'b0; e_f2 = 32'd0;
    for (int i = sz - 1; i >= 0; i--) begin
      if (!e_h1 && lookupReg1 != 5'd0 && exp_q[i][36:32] == lookupReg1) begin
        e_h1 = 1'b1; e_f1 = exp_q[i][31:0];
      end
      if (!e_h2 && lookupReg2 != 5'd0 && exp_q[i][36:32] == lookupReg2) begin
        e_h2 = 1'b1; e_f2 = exp_q[i][31:0];
      end
    end
    chk({tag, "_ready"}, 32'(inIf.in_ready), 32'(e_rdy));
    chk({tag, "_regWrite"}, 32'(regWrite), 32'(e_we));
    chk({tag, "_writeReg"}, 32'(writeReg), 32'(e_wr));
    chk({tag, "_writeData"}, writeData, e_wd);
    chk({tag, "_hit1"}, 32'(hit1), 32'(e_h1));
    chk({tag, "_fwd1"}, fwdData1, e_f1);
    chk({tag, "_hit2"}, 32'(hit2), 32'(e_h2));
    chk({tag, "_fwd2"}, fwdData2, e_f2);
    chk({tag, "_count"}, 32'(count), 32'(sz));
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
    end else begin
      if (e_we) void'(exp_q.pop_front());
      if (inIf.in_valid && e_rdy && inIf.in_reg != 5'd0)
        exp_q.push_back({inIf.in_reg, inIf.in_data});
    end
    if (seen_we && seen_wr != 5'd0) rf[seen_wr] = seen_wd;
    #1;
  endtask

  task automatic run_cycle(input logic rst_i, input logic v, input logic [4:0] r,
                           input logic [31:0] d, input logic de,
                           input logic [4:0] l1, input logic [4:0] l2, input string tag);
    apply(rst_i, v, r, d, de, l1, l2);
    model_check(tag);
    finish_cycle();
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] r, input logic [31:0] d,
                              input logic de, input logic [4:0] l1, input logic [4:0] l2,
                              input logic rdy, input logic we, input logic [4:0] wr,
                              input logic [31:0] wd, input logic h1, input logic [31:0] f1,
                              input logic h2, input logic [31:0] f2, input logic [2:0] cnt);
    vec_t t;
    t.v = v; t.r = r; t.d = d; t.de = de; t.l1 = l1; t.l2 = l2;
    t.e_rdy = rdy; t.e_we = we; t.e_wr = wr; t.e_wd = wd;
    t.e_h1 = h1; t.e_f1 = f1; t.e_h2 = h2; t.e_f2 = f2; t.e_cnt = cnt;
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[22] = 32'h0000_2200;
    rf[23] = 32'h0000_2300;
    rf[24] = 32'h0000_2400;
    seen_we = 1'b0; seen_wr = 5'd0; seen_wd = 32'd0;
    e_rdy = 1'b1; e_we = 1'b0;

    // reset held for two edges, no checks until state is defined
    reset = 1'b1; inIf.in_valid = 1'b0; inIf.in_reg = 5'd0; inIf.in_data = 32'd0;
    drain_en = 1'b1; lookupReg1 = 5'd0; lookupReg2 = 5'd0;
    @(posedge clk);
    @(posedge clk);
    #1;

    // inputs: v r d de l1 l2 | expected: rdy we wr wd h1 f1 h2 f2 cnt
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 1, 5, 6,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    // single write
    vecs.push_back(mk(1, 5, 10, 1, 5, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 5, 0,  1, 1, 5, 10, 1, 10, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 5, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    // $0 drop
    vecs.push_back(mk(1, 0, 32'hDEAD, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    // youngest wins
    vecs.push_back(mk(1, 6, 100, 0, 0, 6,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 6, 200, 0, 0, 6,  1, 0, 6, 100, 0, 0, 1, 100, 1));
    vecs.push_back(mk(0, 0, 0, 0, 6, 6,  1, 0, 6, 100, 1, 200, 1, 200, 2));
    vecs.push_back(mk(0, 0, 0, 1, 6, 6,  1, 1, 6, 100, 1, 200, 1, 200, 2));
    vecs.push_back(mk(0, 0, 0, 1, 6, 6,  1, 1, 6, 200, 1, 200, 1, 200, 1));
    vecs.push_back(mk(0, 0, 0, 1, 6, 6,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    // fill to full, backpressure, then drain with overlap
    vecs.push_back(mk(1, 17, 1, 0, 17, 0,  1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 18, 2, 0, 17, 0,  1, 0, 17, 1, 1, 1, 0, 0, 1));
    vecs.push_back(mk(1, 19, 3, 0, 17, 0,  1, 0, 17, 1, 1, 1, 0, 0, 2));
    vecs.push_back(mk(1, 20, 4, 0, 17, 0,  1, 0, 17, 1, 1, 1, 0, 0, 3));
    vecs.push_back(mk(1, 21, 5, 0, 17, 0,  0, 0, 17, 1, 1, 1, 0, 0, 4));
    vecs.push_back(mk(1, 21, 5, 1, 17, 0,  0, 1, 17, 1, 1, 1, 0, 0, 4));
    vecs.push_back(mk(1, 21, 5, 1, 0, 21,  1, 1, 18, 2, 0, 0, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 21,  1, 1, 19, 3, 0, 0, 1, 5, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 21,  1, 1, 20, 4, 0, 0, 1, 5, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 21,  1, 1, 21, 5, 0, 0, 1, 5, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 21,  1, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(1'b0, vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].de, vecs[i].l1, vecs[i].l2);
      model_check($sformatf("m%0d", i));
      chk($sformatf("v%0d_ready", i), 32'(inIf.in_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_regWrite", i), 32'(regWrite), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_writeReg", i), 32'(writeReg), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d_writeData", i), writeData, vecs[i].e_wd);
      chk($sformatf("v%0d_hit1", i), 32'(hit1), 32'(vecs[i].e_h1));
      chk($sformatf("v%0d_fwd1", i), fwdData1, vecs[i].e_f1);
      chk($sformatf("v%0d_hit2", i), 32'(hit2), 32'(vecs[i].e_h2));
      chk($sformatf("v%0d_fwd2", i), fwdData2, vecs[i].e_f2);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
      finish_cycle();
    end
    chk("rf5_final", rf[5], 32'd10);
    chk("rf6_final", rf[6], 32'd200);
    chk("rf17_final", rf[17], 32'd1);
    chk("rf21_final", rf[21], 32'd5);

    // reset mid-operation with three entries queued
    run_cycle(0, 1, 22, 32'hAAAA_0022, 0, 0, 0, "rq0");
    run_cycle(0, 1, 23, 32'hAAAA_0023, 0, 0, 0, "rq1");
    run_cycle(0, 1, 24, 32'hAAAA_0024, 0, 0, 0, "rq2");
    apply(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd22, 5'd24);
    model_check("rst_cyc");
    chk("rst_cyc_count", 32'(count), 32'd3);
    finish_cycle();
    apply(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd22, 5'd24);
    model_check("post_rst");
    chk("post_rst_regWrite", 32'(regWrite), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_hit1", 32'(hit1), 32'd0);
    finish_cycle();
    for (int i = 0; i < 3; i++) run_cycle(0, 0, 0, 0, 1, 23, 0, "post_rst_idle");
    chk("rf22_kept", rf[22], 32'h0000_2200);
    chk("rf23_kept", rf[23], 32'h0000_2300);
    chk("rf24_kept", rf[24], 32'h0000_2400);

    // randomized traffic with small register range to force collisions and $0
    for (int i = 0; i < 600; i++) begin
      run_cycle($urandom_range(0, 59) == 0,
                $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 7)),
                $urandom,
                $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)),
                "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_write_queue.md
Name: rf_write_queue

Overview:
- Initiator side of the register file write port: buffers pending register writebacks from multi-cycle producers (load unit, mult/div) and drains them into the register file one per cycle.
- Drives writeReg/writeData/regWrite directly.
- Provides forwarding lookups so readers see queued-but-unwritten values.
- Sits between the writeback arbiter and reg_file.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, >=2)
- AW, 2, log2(DEPTH), pointer width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a write request
- in_ready  output  1  queue can accept a request this cycle
- in_reg  input  5  destination register number
- in_data  input  32  value to write
- drain_en  input  1  register file write port available this cycle
- writeReg  output  5  to reg_file writeReg
- writeData  output  32  to reg_file writeData
- regWrite  output  1  to reg_file regWrite
- lookupReg1  input  5  forwarding query 1 (same value as readReg1)
- lookupReg2  input  5  forwarding query 2 (same value as readReg2)
- hit1  output  1  lookupReg1 matches a queued entry
- hit2  output  1  lookupReg2 matches a queued entry
- fwdData1  output  32  youngest matching data for lookupReg1, 0 when no hit
- fwdData2  output  32  youngest matching data for lookupReg2, 0 when no hit
- count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Storage: circular buffer of {reg[4:0], data[31:0]}; head pointer (rd), tail pointer (wr), and count register.
- Reset (sync, at the rising edge with reset=1): count=0, head=tail=0, and entries are don't-care. Pending entries are discarded; no write is issued afterwards.
- Post-reset outputs: regWrite=0, hit1=hit2=0, fwdData=0, in_ready=1, count=0.
- Enqueue: push occurs at the edge when in_valid && in_ready. in_ready = (count != DEPTH), combinational from count.
- $0 rule: a request with in_reg==0 is accepted (handshake completes) but not stored. count and tail stay unchanged.
- Drain path, combinational from the head entry:
  - regWrite = (count != 0) && drain_en.
  - writeReg and writeData = head entry.
  - When count==0, writeReg=0 and writeData=0.
- Pop: head advances at the edge where regWrite=1, coinciding with reg_file's write.
- Push and pop in the same cycle: both pointers advance, count unchanged. Allowed when count==DEPTH only if in_ready was 1, so a full queue refuses the push even while popping (no same-cycle full bypass).
- Pointer wrap: modulo DEPTH; pointers are AW bits wide.
- Forwarding:
  - hitN = 1 if any valid entry (head..tail-1) has reg == lookupRegN and lookupRegN != 0.
  - fwdDataN = data of the youngest such entry, i.e. closest to tail.
  - The head entry being written this cycle still counts as a hit, because reg_file updates only at the edge.
  - Incoming in_* requests are not forwarded in the cycle they arrive; they become visible in the cycle after the push.
- Ordering: writes reach reg_file in acceptance order. Duplicate destinations are all written, oldest first, so the final value is the youngest.
- drain_en=0: queue holds, regWrite=0, and forwarding continues.
- Throughput: one push and one pop per cycle. Latency from accept to write is at least 1 cycle (earliest write is the edge after the push edge).

Decomposition:
- Shared package mips_rf_pkg:
  - REG_ADDR_W=5, DATA_W=32
  - ZERO_REG=5'd0
  - wb_entry_t {reg, data}
- One natural sub-module, rf_fwd_match: a combinational youngest-match search over the entry array for one lookup port, instantiated twice.

Test Plan:
- Reset then idle: hold reset 2 cycles, drain_en=1 -> regWrite=0, count=0, in_ready=1, hit1=hit2=0 for 5 cycles.
- Single write: push (5, 32'd10) with drain_en=1 -> next cycle regWrite=1, writeReg=5, writeData=10. lookupReg1=5 gives hit1=1, fwdData1=10 that cycle. The following cycle count=0; reg_file readReg1=5 returns 10.
- $0 drop: push (0, 32'hDEAD) -> in_ready=1, count stays 0, regWrite never asserts, lookupReg1=0 gives hit1=0.
- Full/backpressure, DEPTH=4, drain_en=0: push (17,1), (18,2), (19,3), (20,4) -> count=4, in_ready=0; push (21,5) is held. Raise drain_en -> writes 17, 18, 19, 20 on consecutive cycles, then 21. count goes 4, 4, ... (push and pop overlap) down to 0.
- Youngest-wins forwarding, drain_en=0: push (6,100), then (6,200) -> hit2=1, fwdData2=200 for lookupReg2=6. On drain, reg_file reg 6 receives 100 then 200 and finally reads 200.
- Reset mid-operation: 3 entries queued, assert reset for one edge -> count=0 and regWrite=0 next cycle; reg_file registers 22–24 are unchanged from their prior values.
